multdiv_ctrl: RTL and testbench

- Sequencing controller for the E-stage multiply/divide unit and its HI/LO registers.
- Accepts mult/div/mthi/mtlo requests from E, latches operation and signedness, and counts the fixed unit latency.
- Produces busy, HI/LO write strobes and the D-stage stall request for any mult/div-class instruction arriving while the unit is occupied.
- Purely control: operand and result data stay in the multdiv datapath.

---
 rtl/multdiv_ctrl.sv | 85 ++++++++
 tb/tb_multdiv_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the E-stage multiply/divide unit: latches the op,
// counts the fixed latency, and generates HI/LO write strobes and D-stage stalls.
module multdiv_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       start_E,
   input  logic             sign_E,
   input  logic [1:0]       mt_E,
   input  logic             clear_E,
   input  logic             divisor_zero,
   input  logic             md_instr_D,
   output logic             busy,
   output logic [1:0]       op_q,
   output logic             sign_q,
   output logic [CNT_W-1:0] cnt,
   output logic             HIWrite,
   output logic             LOWrite,
   output logic             hi_sel_mt,
   output logic             stall_D,
   output logic             protocol_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2} state_t;

   localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

   state_t state;
   logic   dz_q;
   logic   start_v, mt_v, done, res_wr, mt_wr, illegal;

   // Reserved encodings (11) are not requests; a flushed E stage masks both.
   assign start_v = !clear_E && (start_E == 2'b01 || start_E == 2'b10);
   assign mt_v    = !clear_E && (mt_E == 2'b01 || mt_E == 2'b10);

   assign busy    = (state != IDLE);
   assign done    = busy && (cnt == '0);
   assign res_wr  = done && !(state == DIV && dz_q);
   // Start beats a simultaneous mt, so the mt only writes from a quiet idle cycle.
   assign mt_wr   = !busy && !start_v && mt_v;
   assign illegal = (busy && (start_v || mt_v)) || (start_v && mt_v);

   assign HIWrite   = res_wr || (mt_wr && mt_E == 2'b01);
   assign LOWrite   = res_wr || (mt_wr && mt_E == 2'b10);
   assign hi_sel_mt = mt_wr;
   assign stall_D   = md_instr_D && (busy || start_v);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         op_q         <= 2'b00;
         sign_q       <= 1'b0;
         cnt          <= '0;
         dz_q         <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         if (illegal) protocol_err <= 1'b1;
         case (state)
            IDLE: begin
               if (start_v) begin
                  state  <= (start_E == 2'b01) ? MULT : DIV;
                  op_q   <= start_E;
                  sign_q <= sign_E;
                  cnt    <= (start_E == 2'b01) ? MULT_LAST : DIV_LAST;
                  dz_q   <= (start_E == 2'b10) && divisor_zero;
               end
            end
            default: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  op_q  <= 2'b00;
                  dz_q  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed vector table, hand-written
// corner sequences, and random traffic against a cycle-count reference model.
module tb_multdiv_ctrl;
   localparam int MC = 5;
   localparam int DC = 10;
   localparam int CW = 4;

   logic          clk = 1'b0, reset = 1'b0;
   logic [1:0]    start_E = '0, mt_E = '0;
   logic          sign_E = 1'b0, clear_E = 1'b0, divisor_zero = 1'b0, md_instr_D = 1'b0;
   logic          busy, sign_q, HIWrite, LOWrite, hi_sel_mt, stall_D, protocol_err;
   logic [1:0]    op_q;
   logic [CW-1:0] cnt;

   multdiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .start_E(start_E), .sign_E(sign_E), .mt_E(mt_E),
      .clear_E(clear_E), .divisor_zero(divisor_zero), .md_instr_D(md_instr_D),
      .busy(busy), .op_q(op_q), .sign_q(sign_q), .cnt(cnt), .HIWrite(HIWrite),
      .LOWrite(LOWrite), .hi_sel_mt(hi_sel_mt), .stall_D(stall_D), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: remaining busy cycles as a plain integer.
   int         m_rem;
   logic [1:0] m_op;
   logic       m_sign, m_dz, m_err;
   logic       s_hi, s_lo, s_busy;

   task automatic m_reset();
      m_rem = 0; m_op = 2'b00; m_sign = 1'b0; m_dz = 1'b0; m_err = 1'b0;
   endtask

   task automatic m_check_update();
      bit sv, mv, bz, wr, mtw;
      sv  = !clear_E && (start_E == 2'd1 || start_E == 2'd2);
      mv  = !clear_E && (mt_E == 2'd1 || mt_E == 2'd2);
      bz  = (m_rem > 0);
      wr  = (m_rem == 1) && !(m_op == 2'd2 && m_dz);
      mtw = !bz && !sv && mv;
      chk("m_busy",  32'(busy),         32'(bz));
      chk("m_cnt",   32'(cnt),          bz ? 32'(m_rem - 1) : 32'd0);
      chk("m_op",    32'(op_q),         bz ? 32'(m_op) : 32'd0);
      chk("m_sign",  32'(sign_q),       32'(m_sign));
      chk("m_hi",    32'(HIWrite),      32'(wr || (mtw && mt_E == 2'd1)));
      chk("m_lo",    32'(LOWrite),      32'(wr || (mtw && mt_E == 2'd2)));
      chk("m_sel",   32'(hi_sel_mt),    32'(mtw));
      chk("m_stall", 32'(stall_D),      32'(md_instr_D && (bz || sv)));
      chk("m_err",   32'(protocol_err), 32'(m_err));
      if ((bz && (sv || mv)) || (sv && mv)) m_err = 1'b1;
      if (bz) m_rem--;
      else if (sv) begin
         m_rem  = (start_E == 2'd1) ? MC : DC;
         m_op   = start_E;
         m_sign = sign_E;
         m_dz   = (start_E == 2'd2) && divisor_zero;
      end
   endtask

   task automatic drive(input logic [1:0] st, input logic sg, input logic [1:0] mt,
                        input logic clr, input logic dz, input logic md);
      start_E = st; sign_E = sg; mt_E = mt; clear_E = clr; divisor_zero = dz; md_instr_D = md;
   endtask

   task automatic cyc(input logic [1:0] st, input logic sg, input logic [1:0] mt,
                      input logic clr, input logic dz, input logic md);
      drive(st, sg, mt, clr, dz, md);
      @(negedge clk);
      s_hi = HIWrite; s_lo = LOWrite; s_busy = busy;
      m_check_update();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      m_reset();
      @(posedge clk); #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cnt",  32'(cnt), 0);
      chk("rst_op",   32'(op_q), 0);
      chk("rst_sign", 32'(sign_q), 0);
      chk("rst_hilo", 32'({HIWrite, LOWrite, hi_sel_mt, stall_D}), 0);
      chk("rst_err",  32'(protocol_err), 0);
      reset = 1'b1;
   endtask

   typedef struct {
      logic [1:0] st; logic sg; logic [1:0] mt; logic clr; logic dz; logic md;
      logic bsy; logic [3:0] cn; logic [1:0] op; logic sgq;
      logic hi; logic lo; logic sel; logic stl; logic err;
   } vec_t;

   vec_t tbl[$];
   int   busy_n, wr_n, wr_at;

   initial begin
      //            st  sg mt  clr dz md | bsy cnt op sgq hi lo sel stl err
      tbl.push_back('{2'd1,1,2'd0,0,0,1,  0,4'd0,2'd0,0, 0,0,0,1,0});
      tbl.push_back('{2'd0,0,2'd0,0,0,1,  1,4'd4,2'd1,1, 0,0,0,1,0});
      tbl.push_back('{2'd0,0,2'd0,0,0,1,  1,4'd3,2'd1,1, 0,0,0,1,0});
      tbl.push_back('{2'd0,0,2'd0,0,0,1,  1,4'd2,2'd1,1, 0,0,0,1,0});
      tbl.push_back('{2'd0,0,2'd0,0,0,1,  1,4'd1,2'd1,1, 0,0,0,1,0});
      tbl.push_back('{2'd0,0,2'd0,0,0,1,  1,4'd0,2'd1,1, 1,1,0,1,0});
      tbl.push_back('{2'd0,0,2'd0,0,0,1,  0,4'd0,2'd0,1, 0,0,0,0,0});
      tbl.push_back('{2'd0,0,2'd1,0,0,0,  0,4'd0,2'd0,1, 1,0,1,0,0});
      tbl.push_back('{2'd1,0,2'd0,1,0,1,  0,4'd0,2'd0,1, 0,0,0,0,0});
      tbl.push_back('{2'd0,0,2'd2,1,0,0,  0,4'd0,2'd0,1, 0,0,0,0,0});
      tbl.push_back('{2'd3,0,2'd3,0,0,1,  0,4'd0,2'd0,1, 0,0,0,0,0});
      tbl.push_back('{2'd0,0,2'd2,0,0,0,  0,4'd0,2'd0,1, 0,1,1,0,0});
      tbl.push_back('{2'd0,0,2'd0,0,0,0,  0,4'd0,2'd0,1, 0,0,0,0,0});

      do_reset();
      foreach (tbl[i]) begin
         drive(tbl[i].st, tbl[i].sg, tbl[i].mt, tbl[i].clr, tbl[i].dz, tbl[i].md);
         @(negedge clk);
         chk($sformatf("v%0d_busy", i),  32'(busy),         32'(tbl[i].bsy));
         chk($sformatf("v%0d_cnt", i),   32'(cnt),          32'(tbl[i].cn));
         chk($sformatf("v%0d_op", i),    32'(op_q),         32'(tbl[i].op));
         chk($sformatf("v%0d_sign", i),  32'(sign_q),       32'(tbl[i].sgq));
         chk($sformatf("v%0d_hi", i),    32'(HIWrite),      32'(tbl[i].hi));
         chk($sformatf("v%0d_lo", i),    32'(LOWrite),      32'(tbl[i].lo));
         chk($sformatf("v%0d_sel", i),   32'(hi_sel_mt),    32'(tbl[i].sel));
         chk($sformatf("v%0d_stall", i), 32'(stall_D),      32'(tbl[i].stl));
         chk($sformatf("v%0d_err", i),   32'(protocol_err), 32'(tbl[i].err));
         @(posedge clk); #1;
      end

      // Divide by zero: ten busy cycles, no strobes, no error.
      do_reset();
      cyc(2'd2, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
      busy_n = 0; wr_n = 0;
      for (int i = 0; i < DC + 2; i++) begin
         cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
         busy_n += int'(s_busy);
         wr_n   += int'(s_hi) + int'(s_lo);
      end
      chk("dz_busy_cycles", busy_n, DC);
      chk("dz_strobes", wr_n, 0);
      chk("dz_err", 32'(protocol_err), 0);

      // mtlo while busy: dropped and the error sticks.
      do_reset();
      cyc(2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      cyc(2'd0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
      chk("mt_busy_lo", 32'(s_lo), 0);
      for (int i = 0; i < MC + 2; i++) cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("mt_busy_err_sticky", 32'(protocol_err), 1);

      // Second start at cycle 2 of a mult is ignored; original completes at cycle 5.
      do_reset();
      cyc(2'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      wr_at = -1;
      for (int c = 1; c <= MC + 3; c++) begin
         cyc((c == 2) ? 2'd2 : 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
         if (s_hi && wr_at < 0) wr_at = c;
      end
      chk("restart_done_cycle", wr_at, MC);
      chk("restart_err", 32'(protocol_err), 1);
      chk("restart_idle", 32'(busy), 0);

      // Simultaneous start and mt: start wins, mt dropped, error set.
      do_reset();
      cyc(2'd1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
      chk("simul_no_mt", 32'(s_hi), 0);
      cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("simul_started", 32'(s_busy), 1);

      // Asynchronous reset at cycle 3 of a div.
      do_reset();
      cyc(2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("areset_busy", 32'(busy), 0);
      chk("areset_cnt",  32'(cnt), 0);
      chk("areset_op",   32'(op_q), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      m_reset();
      wr_n = 0;
      for (int i = 0; i < DC + 2; i++) begin
         cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
         wr_n += int'(s_hi) + int'(s_lo);
      end
      chk("areset_no_strobe", wr_n, 0);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) do_reset();
         else cyc(($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0, 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0,
                  ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
